// File: rtl/rv32_alu_dispatch.sv
// rtl/rv32_alu_dispatch.sv - EX register driving an external ALU, followed by an in-order writeback buffer
// The ALU itself is outside this block; results are captured into the FIFO when EX advances.
package rv32_alu_dispatch_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_XOR  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_AND  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    OP_A_REG_A  = 2'd0,
    OP_A_FWD    = 2'd1,
    OP_A_CURRPC = 2'd2,
    OP_A_IMM    = 2'd3
  } op_a_sel_e;

  typedef enum logic {
    OP_B_REG_B = 1'b0,
    OP_B_IMM   = 1'b1
  } op_b_sel_e;
endpackage

module rv32_alu_dispatch
  import rv32_alu_dispatch_pkg::*;
#(
  parameter int WbDepth  = 2,
  parameter int CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,

  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  alu_op_e             in_operator_i,
  input  op_a_sel_e           in_op_a_sel_i,
  input  op_b_sel_e           in_op_b_sel_i,
  input  logic [31:0]         in_rs1_data_i,
  input  logic [31:0]         in_rs2_data_i,
  input  logic [31:0]         in_pc_i,
  input  logic [31:0]         in_imm_i,
  input  logic [4:0]          in_rd_addr_i,

  output alu_op_e             alu_operator_o,
  output op_a_sel_e           alu_op_a_mux_sel_o,
  output op_b_sel_e           alu_op_b_mux_sel_o,
  output logic [31:0]         alu_rf_rdata_a_o,
  output logic [31:0]         alu_rf_rdata_b_o,
  output logic [31:0]         alu_pc_o,
  output logic [31:0]         alu_imm_o,
  input  logic [31:0]         alu_result_i,

  output logic                wb_valid_o,
  input  logic                wb_ready_i,
  output logic [4:0]          wb_rd_addr_o,
  output logic [31:0]         wb_result_o,
  output logic                wb_we_o,

  output logic [CntWidth-1:0] retired_cnt_o
);

  localparam int PtrW = (WbDepth > 1) ? $clog2(WbDepth) : 1;
  localparam int CntW = $clog2(WbDepth + 1);
  localparam logic [CntW-1:0] DepthC  = CntW'(WbDepth);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(WbDepth - 1);

  logic            ex_valid;
  alu_op_e         ex_operator;
  op_a_sel_e       ex_a_sel;
  op_b_sel_e       ex_b_sel;
  logic [31:0]     ex_rs1;
  logic [31:0]     ex_rs2;
  logic [31:0]     ex_pc;
  logic [31:0]     ex_imm;
  logic [4:0]      ex_rd;

  logic [4:0]      fifo_rd  [WbDepth];
  logic [31:0]     fifo_res [WbDepth];
  logic            fifo_we  [WbDepth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [CntW-1:0] count;

  logic            wb_pop;
  logic            ex_advance;
  logic            issue_accept;
  logic            fifo_push;
  logic            fifo_pop;

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + 1'b1;
  endfunction

  assign wb_valid_o   = (count != '0);
  assign wb_pop       = wb_valid_o && wb_ready_i;
  // A full buffer can still take the EX result when its head leaves this same cycle.
  assign ex_advance   = ex_valid && ((count < DepthC) || wb_pop);
  assign in_ready_o   = (!ex_valid || ex_advance) && !flush_i;
  assign issue_accept = in_valid_i && in_ready_o;
  assign fifo_push    = ex_advance && !flush_i;
  assign fifo_pop     = wb_pop && !flush_i;

  assign alu_operator_o     = ex_operator;
  assign alu_op_a_mux_sel_o = ex_a_sel;
  assign alu_op_b_mux_sel_o = ex_b_sel;
  assign alu_rf_rdata_a_o   = ex_rs1;
  assign alu_rf_rdata_b_o   = ex_rs2;
  assign alu_pc_o           = ex_pc;
  assign alu_imm_o          = ex_imm;

  assign wb_rd_addr_o = fifo_rd[rd_ptr];
  assign wb_result_o  = fifo_res[rd_ptr];
  assign wb_we_o      = fifo_we[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_valid <= 1'b0;
    end else if (flush_i) begin
      ex_valid <= 1'b0;
    end else if (issue_accept) begin
      ex_valid <= 1'b1;
    end else if (ex_advance) begin
      ex_valid <= 1'b0;
    end
  end

  // Fields are only loaded on accept so an idle EX keeps its last contents.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_operator <= ALU_ADD;
      ex_a_sel    <= OP_A_REG_A;
      ex_b_sel    <= OP_B_REG_B;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_pc       <= '0;
      ex_imm      <= '0;
      ex_rd       <= '0;
    end else if (issue_accept) begin
      ex_operator <= in_operator_i;
      ex_a_sel    <= in_op_a_sel_i;
      ex_b_sel    <= in_op_b_sel_i;
      ex_rs1      <= in_rs1_data_i;
      ex_rs2      <= in_rs2_data_i;
      ex_pc       <= in_pc_i;
      ex_imm      <= in_imm_i;
      ex_rd       <= in_rd_addr_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (fifo_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      if (fifo_push && !fifo_pop) begin
        count <= count + 1'b1;
      end else if (!fifo_push && fifo_pop) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < WbDepth; i++) begin
        fifo_rd[i]  <= '0;
        fifo_res[i] <= '0;
        fifo_we[i]  <= 1'b0;
      end
    end else if (fifo_push) begin
      fifo_rd[wr_ptr]  <= ex_rd;
      fifo_res[wr_ptr] <= alu_result_i;
      fifo_we[wr_ptr]  <= (ex_rd != 5'd0);
    end
  end

  // A handshake completed during a flush cycle still counts as retired.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      retired_cnt_o <= '0;
    end else if (wb_pop) begin
      retired_cnt_o <= retired_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_rv32_alu_dispatch.sv
// tb/tb_rv32_alu_dispatch.sv - self-checking bench for rv32_alu_dispatch
module tb_rv32_alu_dispatch;
  import rv32_alu_dispatch_pkg::*;

  localparam int WbDepth  = 2;
  localparam int CntWidth = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  alu_op_e     in_operator = ALU_ADD;
  op_a_sel_e   in_a_sel = OP_A_REG_A;
  op_b_sel_e   in_b_sel = OP_B_REG_B;
  logic [31:0] in_rs1 = '0, in_rs2 = '0, in_pc = '0, in_imm = '0;
  logic [4:0]  in_rd = '0;
  alu_op_e     alu_operator;
  op_a_sel_e   alu_a_sel;
  op_b_sel_e   alu_b_sel;
  logic [31:0] alu_a, alu_b, alu_pc, alu_imm, alu_result;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic        wb_we;
  logic [CntWidth-1:0] retired;

  int tests = 0;
  int fails = 0;
  logic [CntWidth-1:0] ret_exp = '0;

  always #5 clk = ~clk;

  rv32_alu_dispatch #(.WbDepth(WbDepth), .CntWidth(CntWidth)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_operator_i(in_operator), .in_op_a_sel_i(in_a_sel), .in_op_b_sel_i(in_b_sel),
    .in_rs1_data_i(in_rs1), .in_rs2_data_i(in_rs2), .in_pc_i(in_pc), .in_imm_i(in_imm),
    .in_rd_addr_i(in_rd),
    .alu_operator_o(alu_operator), .alu_op_a_mux_sel_o(alu_a_sel), .alu_op_b_mux_sel_o(alu_b_sel),
    .alu_rf_rdata_a_o(alu_a), .alu_rf_rdata_b_o(alu_b), .alu_pc_o(alu_pc), .alu_imm_o(alu_imm),
    .alu_result_i(alu_result),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_rd_addr_o(wb_rd),
    .wb_result_o(wb_result), .wb_we_o(wb_we), .retired_cnt_o(retired)
  );

  function automatic logic [31:0] alu_ref(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_XOR:  return a ^ b;
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick_a(input op_a_sel_e s, input logic [31:0] rs1, input logic [31:0] pc,
                                         input logic [31:0] imm);
    case (s)
      OP_A_CURRPC: return pc;
      OP_A_IMM:    return imm;
      default:     return rs1;
    endcase
  endfunction

  function automatic logic [31:0] pick_b(input op_b_sel_e s, input logic [31:0] rs2, input logic [31:0] imm);
    return (s == OP_B_IMM) ? imm : rs2;
  endfunction

  always_comb alu_result = alu_ref(alu_operator, pick_a(alu_a_sel, alu_a, alu_pc, alu_imm),
                                   pick_b(alu_b_sel, alu_b, alu_imm));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input alu_op_e op, input op_a_sel_e as, input op_b_sel_e bs, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] pc, input logic [31:0] imm, input logic [4:0] rd);
    in_operator = op; in_a_sel = as; in_b_sel = bs;
    in_rs1 = rs1; in_rs2 = rs2; in_pc = pc; in_imm = imm; in_rd = rd;
    in_valid = 1'b1;
  endtask

  typedef struct {
    alu_op_e     op;
    op_a_sel_e   as;
    op_b_sel_e   bs;
    logic [31:0] rs1, rs2, pc, imm;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        we;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] res;
    logic        we;
    int          acc;
  } item_t;

  vec_t  vecs[11];
  item_t q[$];
  item_t it;

  initial begin
    int idx;
    int seen;
    int edge_cnt;
    logic exp_wbv, exp_pop, exp_rdy;

    vecs[0]  = '{ALU_ADD,  OP_A_REG_A,  OP_B_REG_B, 32'd5,          32'd7,          32'd0,      32'd0,          5'd3,  32'd12,         1'b1};
    vecs[1]  = '{ALU_SLT,  OP_A_REG_A,  OP_B_IMM,   32'hFFFFFFFF,   32'd0,          32'd0,      32'd1,          5'd0,  32'd1,          1'b0};
    vecs[2]  = '{ALU_SUB,  OP_A_REG_A,  OP_B_REG_B, 32'd3,          32'd5,          32'd0,      32'd0,          5'd31, 32'hFFFFFFFE,   1'b1};
    vecs[3]  = '{ALU_XOR,  OP_A_REG_A,  OP_B_REG_B, 32'hF0F0F0F0,   32'h0FF00FF0,   32'd0,      32'd0,          5'd1,  32'hFF00FF00,   1'b1};
    vecs[4]  = '{ALU_SLL,  OP_A_REG_A,  OP_B_IMM,   32'd1,          32'd0,          32'd0,      32'd31,         5'd2,  32'h80000000,   1'b1};
    vecs[5]  = '{ALU_SRA,  OP_A_REG_A,  OP_B_REG_B, 32'h80000000,   32'd4,          32'd0,      32'd0,          5'd4,  32'hF8000000,   1'b1};
    vecs[6]  = '{ALU_SRL,  OP_A_REG_A,  OP_B_REG_B, 32'h80000000,   32'd4,          32'd0,      32'd0,          5'd5,  32'h08000000,   1'b1};
    vecs[7]  = '{ALU_SLTU, OP_A_REG_A,  OP_B_IMM,   32'hFFFFFFFF,   32'd0,          32'd0,      32'd1,          5'd6,  32'd0,          1'b1};
    vecs[8]  = '{ALU_ADD,  OP_A_CURRPC, OP_B_IMM,   32'd9,          32'd0,          32'h1000,   32'h20,         5'd7,  32'h1020,       1'b1};
    vecs[9]  = '{ALU_AND,  OP_A_IMM,    OP_B_REG_B, 32'd0,          32'h12345678,   32'd0,      32'h0000FFFF,   5'd8,  32'h00005678,   1'b1};
    vecs[10] = '{ALU_OR,   OP_A_REG_A,  OP_B_REG_B, 32'h00FF0000,   32'h000000FF,   32'd0,      32'd0,          5'd9,  32'h00FF00FF,   1'b1};

    // reset values
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_operator", 32'(alu_operator), 32'(ALU_ADD));
    check("rst_a_sel", 32'(alu_a_sel), 32'(OP_A_REG_A));
    check("rst_b_sel", 32'(alu_b_sel), 32'(OP_B_REG_B));
    check("rst_data", alu_a | alu_b | alu_pc | alu_imm, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // single ops, no backpressure
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      wb_ready = 1'b1;
      drive(vecs[i].op, vecs[i].as, vecs[i].bs, vecs[i].rs1, vecs[i].rs2, vecs[i].pc, vecs[i].imm, vecs[i].rd);
      #1 check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      #1 check($sformatf("vec%0d_no_bypass", i), 32'(wb_valid), 32'd0);
      @(negedge clk);
      #1;
      check($sformatf("vec%0d_wb_valid", i), 32'(wb_valid), 32'd1);
      check($sformatf("vec%0d_result", i), wb_result, vecs[i].res);
      check($sformatf("vec%0d_rd", i), 32'(wb_rd), 32'(vecs[i].rd));
      check($sformatf("vec%0d_we", i), 32'(wb_we), 32'(vecs[i].we));
      ret_exp++;
      @(negedge clk);
      #1;
      check($sformatf("vec%0d_drained", i), 32'(wb_valid), 32'd0);
      check($sformatf("vec%0d_retired", i), 32'(retired), 32'(ret_exp));
    end

    // backpressure: four back-to-back ops into a two-entry buffer
    wb_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(ALU_ADD, OP_A_REG_A, OP_B_REG_B, 32'd100 + 32'(k), 32'(k), 32'd0, 32'd0, 5'(10 + k));
      #1 check($sformatf("bp_ready%0d", k), 32'(in_ready), 32'd1);
    end
    @(negedge clk);
    drive(ALU_ADD, OP_A_REG_A, OP_B_REG_B, 32'd103, 32'd3, 32'd0, 32'd0, 5'd13);
    #1 check("bp_ready3_stalled", 32'(in_ready), 32'd0);
    @(negedge clk);
    #1 check("bp_ready3_still_stalled", 32'(in_ready), 32'd0);
    check("bp_head_stable", wb_result, 32'd100);
    @(negedge clk);
    wb_ready = 1'b1;
    #1 check("full_pop_push_accept", 32'(in_ready), 32'd1);
    idx = 0;
    for (int c = 0; c < 12 && idx < 4; c++) begin
      if (c > 0) begin
        @(negedge clk);
        in_valid = 1'b0;
        #1;
      end
      if (wb_valid) begin
        check($sformatf("bp_order%0d_result", idx), wb_result, 32'd100 + 32'(2 * idx));
        check($sformatf("bp_order%0d_rd", idx), 32'(wb_rd), 32'(10 + idx));
        ret_exp++;
        idx++;
      end
    end
    check("bp_delivered", 32'(idx), 32'd4);
    @(negedge clk);
    in_valid = 1'b0;
    #1 check("bp_retired", 32'(retired), 32'(ret_exp));

    // flush with three ops in flight; the pop in the flush cycle still retires
    wb_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(ALU_SUB, OP_A_REG_A, OP_B_REG_B, 32'd50, 32'(k), 32'd0, 32'd0, 5'(20 + k));
      #1 check($sformatf("fl_ready%0d", k), 32'(in_ready), 32'd1);
    end
    @(negedge clk);
    flush = 1'b1;
    wb_ready = 1'b1;
    drive(ALU_ADD, OP_A_REG_A, OP_B_REG_B, 32'd1, 32'd1, 32'd0, 32'd0, 5'd1);
    #1 check("fl_ready_during", 32'(in_ready), 32'd0);
    check("fl_pop_during", 32'(wb_valid), 32'd1);
    ret_exp++;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    check("fl_wb_valid_after", 32'(wb_valid), 32'd0);
    check("fl_in_ready_after", 32'(in_ready), 32'd1);
    check("fl_retired", 32'(retired), 32'(ret_exp));
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1 if (wb_valid) seen++;
    end
    check("fl_no_late_wb", 32'(seen), 32'd0);

    // asynchronous reset in the middle of a burst
    wb_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive(ALU_XOR, OP_A_REG_A, OP_B_REG_B, 32'hDEAD0000, 32'(k), 32'h44, 32'h55, 5'(5 + k));
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("ar_wb_valid", 32'(wb_valid), 32'd0);
    check("ar_in_ready", 32'(in_ready), 32'd1);
    check("ar_retired", 32'(retired), 32'd0);
    check("ar_operator", 32'(alu_operator), 32'(ALU_ADD));
    check("ar_data", alu_a | alu_b | alu_pc | alu_imm, 32'd0);
    ret_exp = '0;
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    wb_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1 if (wb_valid) seen++;
    end
    check("ar_no_wb", 32'(seen), 32'd0);

    // randomized traffic against an in-order queue model
    q.delete();
    edge_cnt = 0;
    @(posedge clk);
    for (int c = 0; c < 640; c++) begin
      @(negedge clk);
      in_operator = alu_op_e'($urandom_range(0, 9));
      case ($urandom_range(0, 2))
        0:       in_a_sel = OP_A_REG_A;
        1:       in_a_sel = OP_A_CURRPC;
        default: in_a_sel = OP_A_IMM;
      endcase
      in_b_sel = op_b_sel_e'($urandom_range(0, 1));
      in_rs1 = $urandom; in_rs2 = $urandom; in_pc = $urandom; in_imm = $urandom;
      in_rd = 5'($urandom_range(0, 31));
      in_valid = (c < 600) && ($urandom_range(0, 3) != 0);
      wb_ready = (c >= 600) || ($urandom_range(0, 2) != 0);
      #1;
      exp_wbv = (q.size() > 0) && (edge_cnt >= q[0].acc + 1);
      exp_pop = exp_wbv && wb_ready;
      exp_rdy = (q.size() < WbDepth + 1) || exp_pop;
      check("rnd_wb_valid", 32'(wb_valid), 32'(exp_wbv));
      check("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
      check("rnd_retired", 32'(retired), 32'(ret_exp));
      if (exp_wbv) begin
        check("rnd_result", wb_result, q[0].res);
        check("rnd_rd", 32'(wb_rd), 32'(q[0].rd));
        check("rnd_we", 32'(wb_we), 32'(q[0].we));
      end
      if (exp_pop) begin
        void'(q.pop_front());
        ret_exp++;
      end
      if (in_valid && exp_rdy) begin
        it.rd  = in_rd;
        it.res = alu_ref(in_operator, pick_a(in_a_sel, in_rs1, in_pc, in_imm), pick_b(in_b_sel, in_rs2, in_imm));
        it.we  = (in_rd != 5'd0);
        it.acc = edge_cnt + 1;
        q.push_back(it);
      end
      @(posedge clk);
      edge_cnt++;
    end
    check("rnd_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
